// File: rtl/execute_writeback_stage.sv
// Writeback pipeline register between execute ALUs and the register-file commit port, with a
// held copy of the last committed entry for forwarding. FRCR path built only with EXECUTE_WB_FRCR_EN.
module execute_writeback_stage #(
    parameter int unsigned P_PREV_HOLD = 1
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iEVENT_FLUSH,
    input  logic        iEX_VALID,
    output logic        oEX_LOCK,
    input  logic        iEX_GR_VALID,
    input  logic [31:0] iEX_GR_DATA,
    input  logic [4:0]  iEX_GR_DEST,
    input  logic        iEX_GR_DEST_SYSREG,
    input  logic        iEX_SPR_VALID,
    input  logic [31:0] iEX_SPR_DATA,
    input  logic        iEX_FRCR_VALID,
    input  logic [63:0] iEX_FRCR_DATA,
    output logic        oWB_VALID,
    input  logic        iWB_LOCK,
    output logic        oWB_GR_VALID,
    output logic [31:0] oWB_GR_DATA,
    output logic [4:0]  oWB_GR_DEST,
    output logic        oWB_GR_DEST_SYSREG,
    output logic        oWB_SPR_VALID,
    output logic [31:0] oWB_SPR_DATA,
    output logic        oWB_FRCR_VALID,
    output logic [63:0] oWB_FRCR_DATA,
    output logic        oPREV_WB_GR_VALID,
    output logic [31:0] oPREV_WB_GR_DATA,
    output logic [4:0]  oPREV_WB_GR_DEST,
    output logic        oPREV_WB_GR_DEST_SYSREG,
    output logic        oPREV_WB_SPR_VALID,
    output logic [31:0] oPREV_WB_SPR_DATA,
    output logic        oPREV_WB_FRCR_VALID,
    output logic [63:0] oPREV_WB_FRCR_DATA
);

    typedef enum logic {StEmpty, StFull} state_t;

    localparam logic [2:0] HoldInit = 3'(P_PREV_HOLD);

    state_t      state_q, state_d;
    logic        wb_valid, ex_lock, accept, commit, prev_live;
    logic [2:0]  hold_q;

    logic        wb_gr_valid_q, wb_gr_sysreg_q, wb_spr_valid_q;
    logic [31:0] wb_gr_data_q, wb_spr_data_q;
    logic [4:0]  wb_gr_dest_q;
    logic        prev_gr_valid_q, prev_gr_sysreg_q, prev_spr_valid_q;
    logic [31:0] prev_gr_data_q, prev_spr_data_q;
    logic [4:0]  prev_gr_dest_q;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush suppresses both the commit and any new accept in the same cycle.
    always_comb begin
        state_d  = state_q;
        wb_valid = (state_q == StFull);
        ex_lock  = wb_valid & iWB_LOCK;
        accept   = iEX_VALID & ~ex_lock & ~iEVENT_FLUSH;
        commit   = wb_valid & ~iWB_LOCK & ~iEVENT_FLUSH;
        unique case (state_q)
            StEmpty: begin
                if (accept) state_d = StFull;
            end
            StFull: begin
                if (iEVENT_FLUSH) state_d = StEmpty;
                else if (!iWB_LOCK) state_d = accept ? StFull : StEmpty;
            end
            default: state_d = StEmpty;
        endcase
        if (iRESET_SYNC) state_d = StEmpty;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wb_gr_valid_q  <= 1'b0;
            wb_gr_data_q   <= '0;
            wb_gr_dest_q   <= '0;
            wb_gr_sysreg_q <= 1'b0;
            wb_spr_valid_q <= 1'b0;
            wb_spr_data_q  <= '0;
        end else if (iRESET_SYNC) begin
            wb_gr_valid_q  <= 1'b0;
            wb_gr_data_q   <= '0;
            wb_gr_dest_q   <= '0;
            wb_gr_sysreg_q <= 1'b0;
            wb_spr_valid_q <= 1'b0;
            wb_spr_data_q  <= '0;
        end else if (accept) begin
            wb_gr_valid_q  <= iEX_GR_VALID;
            wb_gr_data_q   <= iEX_GR_DATA;
            wb_gr_dest_q   <= iEX_GR_DEST;
            wb_gr_sysreg_q <= iEX_GR_DEST_SYSREG;
            wb_spr_valid_q <= iEX_SPR_VALID;
            wb_spr_data_q  <= iEX_SPR_DATA;
        end
    end

    // Committed copy survives flushes; only resets clear it.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            prev_gr_valid_q  <= 1'b0;
            prev_gr_data_q   <= '0;
            prev_gr_dest_q   <= '0;
            prev_gr_sysreg_q <= 1'b0;
            prev_spr_valid_q <= 1'b0;
            prev_spr_data_q  <= '0;
            hold_q           <= '0;
        end else if (iRESET_SYNC) begin
            prev_gr_valid_q  <= 1'b0;
            prev_gr_data_q   <= '0;
            prev_gr_dest_q   <= '0;
            prev_gr_sysreg_q <= 1'b0;
            prev_spr_valid_q <= 1'b0;
            prev_spr_data_q  <= '0;
            hold_q           <= '0;
        end else if (commit) begin
            prev_gr_valid_q  <= wb_gr_valid_q;
            prev_gr_data_q   <= wb_gr_data_q;
            prev_gr_dest_q   <= wb_gr_dest_q;
            prev_gr_sysreg_q <= wb_gr_sysreg_q;
            prev_spr_valid_q <= wb_spr_valid_q;
            prev_spr_data_q  <= wb_spr_data_q;
            hold_q           <= HoldInit;
        end else if (hold_q != 3'd0) begin
            hold_q <= hold_q - 3'd1;
        end
    end

    assign prev_live = (hold_q != 3'd0);

`ifdef EXECUTE_WB_FRCR_EN
    logic        wb_frcr_valid_q, prev_frcr_valid_q;
    logic [63:0] wb_frcr_data_q, prev_frcr_data_q;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wb_frcr_valid_q   <= 1'b0;
            wb_frcr_data_q    <= '0;
            prev_frcr_valid_q <= 1'b0;
            prev_frcr_data_q  <= '0;
        end else if (iRESET_SYNC) begin
            wb_frcr_valid_q   <= 1'b0;
            wb_frcr_data_q    <= '0;
            prev_frcr_valid_q <= 1'b0;
            prev_frcr_data_q  <= '0;
        end else begin
            if (accept) begin
                wb_frcr_valid_q <= iEX_FRCR_VALID;
                wb_frcr_data_q  <= iEX_FRCR_DATA;
            end
            if (commit) begin
                prev_frcr_valid_q <= wb_frcr_valid_q;
                prev_frcr_data_q  <= wb_frcr_data_q;
            end
        end
    end

    assign oWB_FRCR_VALID      = wb_valid & wb_frcr_valid_q;
    assign oWB_FRCR_DATA       = wb_frcr_data_q;
    assign oPREV_WB_FRCR_VALID = prev_frcr_valid_q & prev_live;
    assign oPREV_WB_FRCR_DATA  = prev_frcr_data_q;
`else
    logic unused_frcr;
    assign unused_frcr         = iEX_FRCR_VALID ^ (^iEX_FRCR_DATA);
    assign oWB_FRCR_VALID      = 1'b0;
    assign oWB_FRCR_DATA       = 64'h0;
    assign oPREV_WB_FRCR_VALID = 1'b0;
    assign oPREV_WB_FRCR_DATA  = 64'h0;
`endif

    assign oEX_LOCK                = ex_lock;
    assign oWB_VALID               = wb_valid;
    assign oWB_GR_VALID            = wb_valid & wb_gr_valid_q;
    assign oWB_GR_DATA             = wb_gr_data_q;
    assign oWB_GR_DEST             = wb_gr_dest_q;
    assign oWB_GR_DEST_SYSREG      = wb_gr_sysreg_q;
    assign oWB_SPR_VALID           = wb_valid & wb_spr_valid_q;
    assign oWB_SPR_DATA            = wb_spr_data_q;
    assign oPREV_WB_GR_VALID       = prev_gr_valid_q & prev_live;
    assign oPREV_WB_GR_DATA        = prev_gr_data_q;
    assign oPREV_WB_GR_DEST        = prev_gr_dest_q;
    assign oPREV_WB_GR_DEST_SYSREG = prev_gr_sysreg_q;
    assign oPREV_WB_SPR_VALID      = prev_spr_valid_q & prev_live;
    assign oPREV_WB_SPR_DATA       = prev_spr_data_q;

endmodule

// File: tb/tb_execute_writeback_stage.sv
// Bench for execute_writeback_stage: vector table, directed corner sequences and random traffic
// checked against an entry/commit-age reference model. Honours EXECUTE_WB_FRCR_EN.
module tb_execute_writeback_stage;

    localparam int HOLD = 3;

    logic        iCLOCK, inRESET, iRESET_SYNC, iEVENT_FLUSH, iEX_VALID, oEX_LOCK;
    logic        iEX_GR_VALID, iEX_GR_DEST_SYSREG, iEX_SPR_VALID, iEX_FRCR_VALID, iWB_LOCK;
    logic [31:0] iEX_GR_DATA, iEX_SPR_DATA;
    logic [4:0]  iEX_GR_DEST;
    logic [63:0] iEX_FRCR_DATA;
    logic        oWB_VALID, oWB_GR_VALID, oWB_GR_DEST_SYSREG, oWB_SPR_VALID, oWB_FRCR_VALID;
    logic [31:0] oWB_GR_DATA, oWB_SPR_DATA, oPREV_WB_GR_DATA, oPREV_WB_SPR_DATA;
    logic [4:0]  oWB_GR_DEST, oPREV_WB_GR_DEST;
    logic [63:0] oWB_FRCR_DATA, oPREV_WB_FRCR_DATA;
    logic        oPREV_WB_GR_VALID, oPREV_WB_GR_DEST_SYSREG, oPREV_WB_SPR_VALID;
    logic        oPREV_WB_FRCR_VALID;

    execute_writeback_stage #(.P_PREV_HOLD(HOLD)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
        .iEVENT_FLUSH(iEVENT_FLUSH), .iEX_VALID(iEX_VALID), .oEX_LOCK(oEX_LOCK),
        .iEX_GR_VALID(iEX_GR_VALID), .iEX_GR_DATA(iEX_GR_DATA), .iEX_GR_DEST(iEX_GR_DEST),
        .iEX_GR_DEST_SYSREG(iEX_GR_DEST_SYSREG), .iEX_SPR_VALID(iEX_SPR_VALID),
        .iEX_SPR_DATA(iEX_SPR_DATA), .iEX_FRCR_VALID(iEX_FRCR_VALID),
        .iEX_FRCR_DATA(iEX_FRCR_DATA), .oWB_VALID(oWB_VALID), .iWB_LOCK(iWB_LOCK),
        .oWB_GR_VALID(oWB_GR_VALID), .oWB_GR_DATA(oWB_GR_DATA), .oWB_GR_DEST(oWB_GR_DEST),
        .oWB_GR_DEST_SYSREG(oWB_GR_DEST_SYSREG), .oWB_SPR_VALID(oWB_SPR_VALID),
        .oWB_SPR_DATA(oWB_SPR_DATA), .oWB_FRCR_VALID(oWB_FRCR_VALID),
        .oWB_FRCR_DATA(oWB_FRCR_DATA), .oPREV_WB_GR_VALID(oPREV_WB_GR_VALID),
        .oPREV_WB_GR_DATA(oPREV_WB_GR_DATA), .oPREV_WB_GR_DEST(oPREV_WB_GR_DEST),
        .oPREV_WB_GR_DEST_SYSREG(oPREV_WB_GR_DEST_SYSREG),
        .oPREV_WB_SPR_VALID(oPREV_WB_SPR_VALID), .oPREV_WB_SPR_DATA(oPREV_WB_SPR_DATA),
        .oPREV_WB_FRCR_VALID(oPREV_WB_FRCR_VALID), .oPREV_WB_FRCR_DATA(oPREV_WB_FRCR_DATA)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one pending entry, the last committed entry, and edges since that commit.
    typedef struct packed {
        logic        gr_v;
        logic [31:0] gr_d;
        logic [4:0]  dest;
        logic        sys;
        logic        spr_v;
        logic [31:0] spr_d;
        logic        frcr_v;
        logic [63:0] frcr_d;
    } entry_t;

    entry_t m_cur, m_prev;
    bit     m_full;
    int     m_age;

    function automatic entry_t in_entry();
        entry_t e;
        e.gr_v  = iEX_GR_VALID;
        e.gr_d  = iEX_GR_DATA;
        e.dest  = iEX_GR_DEST;
        e.sys   = iEX_GR_DEST_SYSREG;
        e.spr_v = iEX_SPR_VALID;
        e.spr_d = iEX_SPR_DATA;
`ifdef EXECUTE_WB_FRCR_EN
        e.frcr_v = iEX_FRCR_VALID;
        e.frcr_d = iEX_FRCR_DATA;
`else
        e.frcr_v = 1'b0;
        e.frcr_d = 64'h0;
`endif
        return e;
    endfunction

    task automatic model_reset();
        m_full = 0;
        m_cur  = '0;
        m_prev = '0;
        m_age  = HOLD;
    endtask

    task automatic model_edge();
        bit commit, accept;
        if (iRESET_SYNC) begin
            model_reset();
            return;
        end
        commit = m_full && !iWB_LOCK && !iEVENT_FLUSH;
        accept = iEX_VALID && !(m_full && iWB_LOCK) && !iEVENT_FLUSH;
        if (commit) begin
            m_prev = m_cur;
            m_age  = 0;
        end else if (m_age < HOLD) begin
            m_age++;
        end
        if (accept) begin
            m_cur  = in_entry();
            m_full = 1;
        end else if (commit || iEVENT_FLUSH) begin
            m_full = 0;
        end
    endtask

    task automatic check_all();
        bit pv;
        pv = (m_age < HOLD);
        chk("ex_lock", 64'(oEX_LOCK), 64'(m_full && iWB_LOCK));
        chk("wb_valid", 64'(oWB_VALID), 64'(m_full));
        chk("wb_gr_valid", 64'(oWB_GR_VALID), 64'(m_full && m_cur.gr_v));
        chk("wb_gr_data", 64'(oWB_GR_DATA), 64'(m_cur.gr_d));
        chk("wb_gr_dest", 64'(oWB_GR_DEST), 64'(m_cur.dest));
        chk("wb_gr_sys", 64'(oWB_GR_DEST_SYSREG), 64'(m_cur.sys));
        chk("wb_spr_valid", 64'(oWB_SPR_VALID), 64'(m_full && m_cur.spr_v));
        chk("wb_spr_data", 64'(oWB_SPR_DATA), 64'(m_cur.spr_d));
        chk("wb_frcr_valid", 64'(oWB_FRCR_VALID), 64'(m_full && m_cur.frcr_v));
        chk("wb_frcr_data", oWB_FRCR_DATA, m_cur.frcr_d);
        chk("prev_gr_valid", 64'(oPREV_WB_GR_VALID), 64'(pv && m_prev.gr_v));
        chk("prev_gr_data", 64'(oPREV_WB_GR_DATA), 64'(m_prev.gr_d));
        chk("prev_gr_dest", 64'(oPREV_WB_GR_DEST), 64'(m_prev.dest));
        chk("prev_gr_sys", 64'(oPREV_WB_GR_DEST_SYSREG), 64'(m_prev.sys));
        chk("prev_spr_valid", 64'(oPREV_WB_SPR_VALID), 64'(pv && m_prev.spr_v));
        chk("prev_spr_data", 64'(oPREV_WB_SPR_DATA), 64'(m_prev.spr_d));
        chk("prev_frcr_valid", 64'(oPREV_WB_FRCR_VALID), 64'(pv && m_prev.frcr_v));
        chk("prev_frcr_data", oPREV_WB_FRCR_DATA, m_prev.frcr_d);
    endtask

    // Inputs are changed 1 time unit after a rising edge; outputs are checked there too.
    task automatic tick();
        model_edge();
        @(posedge iCLOCK);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        iRESET_SYNC = 0; iEVENT_FLUSH = 0; iEX_VALID = 0; iWB_LOCK = 0;
        iEX_GR_VALID = 0; iEX_GR_DATA = '0; iEX_GR_DEST = '0; iEX_GR_DEST_SYSREG = 0;
        iEX_SPR_VALID = 0; iEX_SPR_DATA = '0; iEX_FRCR_VALID = 0; iEX_FRCR_DATA = '0;
    endtask

    typedef struct {
        bit          ex_valid, lock, flush;
        logic [31:0] data;
        logic [4:0]  dest;
        bit          e_wbv, e_lock;
        logic [31:0] e_wbd;
        logic [4:0]  e_dest;
        bit          e_pv;
        logic [31:0] e_pd;
    } vec_t;

    vec_t vecs[9];
    int   pv_cycles;

    initial begin
        // Expectations after each row's edge, with HOLD = 3, starting from an empty stage.
        vecs[0] = '{1, 0, 0, 32'h1234, 5'd5, 1, 0, 32'h1234, 5'd5, 0, 32'h0};
        vecs[1] = '{0, 0, 0, 32'h0,    5'd0, 0, 0, 32'h1234, 5'd5, 1, 32'h1234};
        vecs[2] = '{1, 1, 0, 32'hA5A5, 5'd3, 1, 1, 32'hA5A5, 5'd3, 1, 32'h1234};
        vecs[3] = '{1, 1, 0, 32'h1111, 5'd4, 1, 1, 32'hA5A5, 5'd3, 1, 32'h1234};
        vecs[4] = '{1, 1, 0, 32'h2222, 5'd4, 1, 1, 32'hA5A5, 5'd3, 0, 32'h1234};
        vecs[5] = '{1, 0, 0, 32'hBEEF, 5'd9, 1, 0, 32'hBEEF, 5'd9, 1, 32'hA5A5};
        vecs[6] = '{0, 0, 1, 32'h0,    5'd0, 0, 0, 32'hBEEF, 5'd9, 1, 32'hA5A5};
        vecs[7] = '{1, 0, 1, 32'h7777, 5'd7, 0, 0, 32'hBEEF, 5'd9, 1, 32'hA5A5};
        vecs[8] = '{0, 0, 0, 32'h0,    5'd0, 0, 0, 32'hBEEF, 5'd9, 0, 32'hA5A5};

        idle_inputs();
        inRESET = 0;
        model_reset();
        #12;
        check_all();
        inRESET = 1;
        @(posedge iCLOCK);
        #1;

        // Flow, stall, back-to-back commit, flush and flush-vs-valid.
        foreach (vecs[i]) begin
            iEX_VALID = vecs[i].ex_valid; iWB_LOCK = vecs[i].lock; iEVENT_FLUSH = vecs[i].flush;
            iEX_GR_VALID = 1; iEX_GR_DATA = vecs[i].data; iEX_GR_DEST = vecs[i].dest;
            tick();
            chk($sformatf("vec%0d_wb_valid", i), 64'(oWB_VALID), 64'(vecs[i].e_wbv));
            chk($sformatf("vec%0d_ex_lock", i), 64'(oEX_LOCK), 64'(vecs[i].e_lock));
            chk($sformatf("vec%0d_wb_data", i), 64'(oWB_GR_DATA), 64'(vecs[i].e_wbd));
            chk($sformatf("vec%0d_wb_dest", i), 64'(oWB_GR_DEST), 64'(vecs[i].e_dest));
            chk($sformatf("vec%0d_prev_valid", i), 64'(oPREV_WB_GR_VALID), 64'(vecs[i].e_pv));
            chk($sformatf("vec%0d_prev_data", i), 64'(oPREV_WB_GR_DATA), 64'(vecs[i].e_pd));
        end
        idle_inputs();
        tick();

        // SPR and FRCR carried together, then committed.
        iEX_VALID = 1; iEX_SPR_VALID = 1; iEX_SPR_DATA = 32'h0000_F000;
        iEX_FRCR_VALID = 1; iEX_FRCR_DATA = 64'h1_0000_0002; iWB_LOCK = 1;
        tick();
        chk("spr_wb_valid", 64'(oWB_SPR_VALID), 64'd1);
        chk("spr_wb_data", 64'(oWB_SPR_DATA), 64'h0000_F000);
`ifdef EXECUTE_WB_FRCR_EN
        chk("frcr_wb_data", oWB_FRCR_DATA, 64'h1_0000_0002);
`else
        chk("frcr_wb_data", oWB_FRCR_DATA, 64'h0);
`endif
        idle_inputs();
        tick();
        chk("spr_prev_valid", 64'(oPREV_WB_SPR_VALID), 64'd1);
        chk("spr_prev_data", 64'(oPREV_WB_SPR_DATA), 64'h0000_F000);
`ifdef EXECUTE_WB_FRCR_EN
        chk("frcr_prev_valid", 64'(oPREV_WB_FRCR_VALID), 64'd1);
        chk("frcr_prev_data", oPREV_WB_FRCR_DATA, 64'h1_0000_0002);
`else
        chk("frcr_prev_valid", 64'(oPREV_WB_FRCR_VALID), 64'd0);
        chk("frcr_prev_data", oPREV_WB_FRCR_DATA, 64'h0);
`endif
        repeat (4) tick();

        // Commits on two consecutive cycles: PREV stays valid HOLD cycles after the second.
        iEX_VALID = 1; iEX_GR_VALID = 1; iEX_GR_DATA = 32'hAAAA_0001; iEX_GR_DEST = 5'd1;
        tick();
        iEX_GR_DATA = 32'hBBBB_0002; iEX_GR_DEST = 5'd2;
        tick();
        chk("cnt_first_commit", 64'(oPREV_WB_GR_DATA), 64'hAAAA_0001);
        idle_inputs();
        pv_cycles = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) chk("cnt_second_commit", 64'(oPREV_WB_GR_DATA), 64'hBBBB_0002);
            if (oPREV_WB_GR_VALID) pv_cycles++;
        end
        chk("cnt_prev_valid_cycles", 64'(pv_cycles), 64'(HOLD + 1));

        // Async reset while holding an entry: outputs clear without a clock edge.
        iEX_VALID = 1; iEX_GR_VALID = 1; iEX_GR_DATA = 32'hCAFE; iWB_LOCK = 1;
        tick();
        tick();
        #2;
        inRESET = 0;
        #1;
        model_reset();
        check_all();
        #2;
        idle_inputs();
        inRESET = 1;
        tick();
        chk("post_reset_ex_lock", 64'(oEX_LOCK), 64'd0);
        chk("post_reset_wb_valid", 64'(oWB_VALID), 64'd0);

        // Random traffic, including occasional sync resets and flushes.
        for (int n = 0; n < 600; n++) begin
            iRESET_SYNC        = ($urandom_range(0, 40) == 0);
            iEVENT_FLUSH       = ($urandom_range(0, 9) == 0);
            iEX_VALID          = ($urandom_range(0, 3) != 0);
            iWB_LOCK           = ($urandom_range(0, 2) == 0);
            iEX_GR_VALID       = $urandom_range(0, 1) == 1;
            iEX_GR_DATA        = 32'($urandom);
            iEX_GR_DEST        = 5'($urandom);
            iEX_GR_DEST_SYSREG = $urandom_range(0, 1) == 1;
            iEX_SPR_VALID      = $urandom_range(0, 1) == 1;
            iEX_SPR_DATA       = 32'($urandom);
            iEX_FRCR_VALID     = $urandom_range(0, 1) == 1;
            iEX_FRCR_DATA      = {32'($urandom), 32'($urandom)};
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
